// File: rtl/discrete_gated_vco_voice.sv
// discrete_gated_vco_voice: one gated voice. It has a square LFO, a two-rate VCO,
// a slewed ADSR-style envelope, a one-pole high-pass and asymmetric output shaping.
// All state advances only on the audio_clk_en sample strobe.
// Ports:
//   clk, I_RSTn (async active-low), audio_clk_en (sample strobe),
//   gate (voice enable), busy (FSM not IDLE), env_out (envelope), out (audio).
// Build option: DISCRETE_VOICE_SATURATE_EN clamps the shaped output to W bits.
// Without it, the shaped output wraps in two's complement.
module discrete_gated_vco_voice #(
    parameter int W            = 16,
    parameter int PHASE_BITS   = 24,
    parameter int ENV_LEVEL    = 6826,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 16,
    parameter int LFO_HALF     = 1200,
    parameter int VCO_INC_HI   = 139810,
    parameter int VCO_INC_LO   = 69905,
    parameter int HP_SHIFT     = 6
) (
    input  logic                clk,
    input  logic                I_RSTn,
    input  logic                audio_clk_en,
    input  logic                gate,
    output logic                busy,
    output logic signed [W-1:0] env_out,
    output logic signed [W-1:0] out
);

    localparam int XW = W + 2;
    localparam int CW = (LFO_HALF > 1) ? $clog2(LFO_HALF) : 1;

    localparam logic [W-1:0] K_LEVEL = W'(ENV_LEVEL);
    localparam logic [W-1:0] K_ATK   = W'(ATTACK_STEP);
    localparam logic [W-1:0] K_REL   = W'(RELEASE_STEP);

    localparam logic [CW-1:0] K_CNT_LAST = CW'(LFO_HALF - 1);

    localparam logic [PHASE_BITS-1:0] K_INC_HI = PHASE_BITS'(VCO_INC_HI);
    localparam logic [PHASE_BITS-1:0] K_INC_LO = PHASE_BITS'(VCO_INC_LO);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ATTACK,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    state_t w_st_att;
    state_t w_st_rel;

    logic r_busy;
    logic w_busy_nxt;
    logic w_restart;

    logic [W-1:0] r_env;
    logic [W-1:0] w_env_nxt;
    logic [W-1:0] w_env_up;
    logic [W-1:0] w_env_att;
    logic [W-1:0] w_env_rel;

    logic [CW-1:0]         r_lfo_cnt;
    logic                  r_lfo;
    logic [PHASE_BITS-1:0] r_phase;
    logic                  w_vco_sq;

    logic [W-1:0]         r_voice;
    logic signed [XW-1:0] r_lp;
    logic signed [XW-1:0] r_hp;
    logic signed [XW-1:0] w_diff;
    logic signed [XW-1:0] w_lp_nxt;
    logic signed [W-1:0]  r_out;
    logic signed [W-1:0]  w_out_nxt;

    // Envelope candidates. The envelope never exceeds ENV_LEVEL < 2^(W-1),
    // so unsigned W-bit arithmetic cannot overflow here.
    assign w_env_up  = r_env + K_ATK;
    assign w_env_att = (w_env_up >= K_LEVEL) ? K_LEVEL : w_env_up;
    assign w_env_rel = (r_env > K_REL) ? (r_env - K_REL) : '0;

    // The state entered on this strobe follows from where the envelope lands.
    assign w_st_att = (w_env_att == K_LEVEL) ? S_SUSTAIN : S_ATTACK;
    assign w_st_rel = (w_env_rel == '0) ? S_IDLE : S_RELEASE;

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else if (audio_clk_en) begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:    w_state_nxt = gate ? w_st_att : S_IDLE;
            S_ATTACK:  w_state_nxt = gate ? w_st_att : w_st_rel;
            S_SUSTAIN: w_state_nxt = gate ? w_st_att : w_st_rel;
            S_RELEASE: w_state_nxt = gate ? w_st_att : w_st_rel;
        endcase
    end

    // The envelope takes the action of the state being entered. A retrigger
    // therefore climbs on the same tick, and a gate drop falls on the same tick.
    always_comb begin
        w_env_nxt  = '0;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_restart  = (r_state == S_IDLE) && gate;
        unique case (w_state_nxt)
            S_IDLE:    w_env_nxt = '0;
            S_ATTACK:  w_env_nxt = w_env_att;
            S_SUSTAIN: w_env_nxt = w_env_att;
            S_RELEASE: w_env_nxt = w_env_rel;
        endcase
    end

    assign w_vco_sq = r_phase[PHASE_BITS-1];

    // The high-pass output is the input minus its one-pole low-pass.
    assign w_diff   = $signed({2'b00, r_voice}) - r_lp;
    assign w_lp_nxt = r_lp + (w_diff >>> HP_SHIFT);

    function automatic logic signed [XW-1:0] f_shape(
        input logic signed [XW-1:0] y
    );
        if (y > 0) begin
            return y + (y >>> 1);
        end
        return (y >>> 1) + (y >>> 2);
    endfunction

`ifdef DISCRETE_VOICE_SATURATE_EN
    localparam logic signed [XW-1:0] K_MAX = XW'((2 ** (W - 1)) - 1);
    localparam logic signed [XW-1:0] K_MIN = ~K_MAX;

    logic signed [XW-1:0] w_shp;

    assign w_shp = f_shape(r_hp);

    always_comb begin
        w_out_nxt = w_shp[W-1:0];
        if (w_shp > K_MAX) begin
            w_out_nxt = K_MAX[W-1:0];
        end else if (w_shp < K_MIN) begin
            w_out_nxt = K_MIN[W-1:0];
        end
    end
`else
    assign w_out_nxt = W'(f_shape(r_hp));
`endif

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            r_env     <= '0;
            r_lfo_cnt <= '0;
            r_lfo     <= 1'b1;
            r_phase   <= '0;
            r_voice   <= '0;
            r_lp      <= '0;
            r_hp      <= '0;
            r_out     <= '0;
        end else if (audio_clk_en) begin
            r_env <= w_env_nxt;
            if (w_restart) begin
                r_lfo_cnt <= '0;
                r_lfo     <= 1'b1;
                r_phase   <= '0;
            end else begin
                r_phase <= r_phase + (r_lfo ? K_INC_HI : K_INC_LO);
                if (r_state != S_IDLE) begin
                    if (r_lfo_cnt == K_CNT_LAST) begin
                        r_lfo_cnt <= '0;
                        r_lfo     <= ~r_lfo;
                    end else begin
                        r_lfo_cnt <= r_lfo_cnt + CW'(1);
                    end
                end
            end
            r_voice <= w_vco_sq ? r_env : '0;
            r_lp    <= w_lp_nxt;
            r_hp    <= w_diff;
            r_out   <= w_out_nxt;
        end
    end

    assign busy    = r_busy;
    assign env_out = r_env;
    assign out     = r_out;

endmodule

// File: tb/tb_discrete_gated_vco_voice.sv
// Directed bench for discrete_gated_vco_voice.
// Three instances: the default build, a short-LFO build, and a narrow overflow build.
module tb_discrete_gated_vco_voice;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic gate_a;
    logic gate_b;
    logic gate_c;

    logic               busy_a;
    logic signed [15:0] env_a;
    logic signed [15:0] out_a;
    logic               busy_b;
    logic signed [15:0] env_b;
    logic signed [15:0] out_b;
    logic               busy_c;
    logic signed [11:0] env_c;
    logic signed [11:0] out_c;

    int n_pass  = 0;
    int n_total = 0;

    localparam longint HI = 139810;
    localparam longint LO = 69905;

    always #5 clk = ~clk;

    discrete_gated_vco_voice dut_a (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .gate(gate_a),
        .busy(busy_a), .env_out(env_a), .out(out_a)
    );

    discrete_gated_vco_voice #(.LFO_HALF(4)) dut_b (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .gate(gate_b),
        .busy(busy_b), .env_out(env_b), .out(out_b)
    );

    discrete_gated_vco_voice #(
        .W(12), .ENV_LEVEL(2047), .ATTACK_STEP(2047), .HP_SHIFT(10),
        .VCO_INC_HI(8388608), .VCO_INC_LO(8388608)
    ) dut_c (
        .clk(clk), .I_RSTn(rst_n), .audio_clk_en(en), .gate(gate_c),
        .busy(busy_c), .env_out(env_c), .out(out_c)
    );

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One strobe, then three quiet clocks; returns 1 time unit after an edge.
    task automatic tick();
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int first_out;
        int found;
        logic [23:0] prev;
        logic [23:0] delta;
        longint exp_out;

        rst_n  = 1'b0;
        en     = 1'b0;
        gate_a = 1'b0;
        gate_b = 1'b0;
        gate_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_env", env_a, 0);
        check("rst_out", out_a, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No strobe: nothing moves even with gate high.
        gate_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("nostrobe_busy", busy_a, 0);
        check("nostrobe_env", env_a, 0);

        // Attack from IDLE up to the clamp.
        first_out = 0;
        for (int s = 1; s <= 108; s++) begin
            tick();
            if (first_out == 0 && out_a != 0) first_out = s;
            if (s == 1) begin
                check("atk1_busy", busy_a, 1);
                check("atk1_env", env_a, 64);
            end
            if (s == 2) check("atk2_env", env_a, 128);
            if (s == 65) check("atk65_out", out_a, 5952);
            if (s == 66) check("atk66_out", out_a, 5955);
            if (s == 106) check("atk106_env", env_a, 6784);
            if (s == 107) begin
                check("atk107_env", env_a, 6826);
                check("atk107_busy", busy_a, 1);
            end
            if (s == 108) check("sus_hold_env", env_a, 6826);
        end
        check("first_out_strobe", first_out, 65);

        // Release from SUSTAIN down to IDLE.
        gate_a = 1'b0;
        for (int k = 1; k <= 428; k++) begin
            tick();
            if (k == 1) check("rel1_env", env_a, 6810);
            if (k == 426) begin
                check("rel426_env", env_a, 10);
                check("rel426_busy", busy_a, 1);
            end
            if (k == 427) begin
                check("rel427_env", env_a, 0);
                check("rel427_busy", busy_a, 0);
            end
            if (k == 428) check("idle_env", env_a, 0);
        end

        // Retrigger mid-release: climb from the current level, keep the LFO count.
        gate_a = 1'b1;
        repeat (50) tick();
        check("rt_attack_env", env_a, 3200);
        gate_a = 1'b0;
        repeat (13) tick();
        check("rt_release_env", env_a, 2992);
        gate_a = 1'b1;
        tick();
        check("rt_env", env_a, 3056);
        check("rt_busy", busy_a, 1);
        check("rt_lfo_cnt", dut_a.r_lfo_cnt, 63);
        tick();
        check("rt_next_env", env_a, 3120);

        // Gate toggling on every strobe.
        gate_a = 1'b0;
        tick();
        check("tog1_env", env_a, 3104);
        gate_a = 1'b1;
        tick();
        check("tog2_env", env_a, 3168);
        gate_a = 1'b0;
        tick();
        check("tog3_env", env_a, 3152);
        check("tog3_busy", busy_a, 1);

        // Back to SUSTAIN, then an asynchronous reset mid-note.
        gate_a = 1'b1;
        for (int i = 1; i <= 58; i++) begin
            tick();
            if (i == 57) check("re_atk57_env", env_a, 6800);
            if (i == 58) check("re_atk58_env", env_a, 6826);
        end
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (out_a != 0) found = 1;
            else tick();
        end
        check("sus_out_nonzero", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", out_a, 0);
        check("arst_env", env_a, 0);
        check("arst_busy", busy_a, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        gate_a = 1'b0;
        repeat (3) tick();
        check("post_rst_out", out_a, 0);
        check("post_rst_env", env_a, 0);
        check("post_rst_busy", busy_a, 0);
        gate_a = 1'b1;
        tick();
        check("post_rst_gate_busy", busy_a, 1);
        check("post_rst_gate_env", env_a, 64);
        gate_a = 1'b0;

        // Short LFO: the rate alternates in blocks of four strobes.
        gate_b = 1'b1;
        tick();
        check("lfo_restart_phase", dut_b.r_phase, 0);
        check("lfo_restart_lfo", dut_b.r_lfo, 1);
        prev = dut_b.r_phase;
        for (int n = 2; n <= 13; n++) begin
            tick();
            delta = dut_b.r_phase - prev;
            prev  = dut_b.r_phase;
            check($sformatf("phase_delta_%0d", n), delta,
                  (((n - 2) / 4) % 2 == 0) ? HI : LO);
            if (n == 4) check("lfo_s4", dut_b.r_lfo, 1);
            if (n == 5) check("lfo_s5", dut_b.r_lfo, 0);
            if (n == 8) check("lfo_s8", dut_b.r_lfo, 0);
            if (n == 9) check("lfo_s9", dut_b.r_lfo, 1);
        end

        // Narrow build with a full-scale square: shaping overflows W bits.
`ifdef DISCRETE_VOICE_SATURATE_EN
        exp_out = 2047;
`else
        exp_out = -1026;
`endif
        gate_c = 1'b1;
        tick();
        check("nar_env", env_c, 2047);
        check("nar_busy", busy_c, 1);
        for (int n = 2; n <= 7; n++) begin
            tick();
            if (n == 4) check("nar_out4", out_c, 0);
            if (n == 5) check("nar_out5", out_c, exp_out);
            if (n == 6) check("nar_out6", out_c, -2);
            if (n == 7) check("nar_out7", out_c, exp_out);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
